// File: rtl/bpsk_packet_assemble.sv
// Purpose : hunt a sync word (with bit-error tolerance) in a demodulated BPSK bit stream, then gather PACKET_WIDTH LSB-first bytes into a parallel packet.
// Latency : sync_lock rises one edge after the last sync bit; ready rises one edge after the last payload bit.
// Backpres: none towards the slicer; bits arriving while a packet is held are dropped and flagged on overrun.
//
// Ports
//   clk        : single system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bit_in     : demodulated bit, qualified by bit_valid
//   bit_valid  : one-cycle strobe per recovered bit
//   done       : downstream consumed the held packet (only looked at while holding)
//   sys_packet : assembled packet, byte 0 is the first byte received
//   ready      : packet complete and stable
//   sync_lock  : high while collecting or holding
//   overrun    : one-cycle pulse per bit dropped while holding
module bpsk_packet_assemble #(
    parameter int                    PACKET_WIDTH = 4,
    parameter int                    SYNC_WIDTH   = 16,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD    = SYNC_WIDTH'(16'h2DD4),
    parameter int                    SYNC_TOL     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    input  logic                         done,
    output logic [PACKET_WIDTH-1:0][7:0] sys_packet,
    output logic                         ready,
    output logic                         sync_lock,
    output logic                         overrun
);

    localparam int CNT_W = $clog2(SYNC_WIDTH + 1);
    localparam int IDX_W = (PACKET_WIDTH > 1) ? $clog2(PACKET_WIDTH) : 1;

    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(SYNC_WIDTH);
    // A tolerance at or above the word length accepts anything; clamp it so it fits the counter.
    localparam logic [CNT_W-1:0] TOL_CNT   = (SYNC_TOL >= SYNC_WIDTH) ? FILL_FULL : CNT_W'(SYNC_TOL);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PACKET_WIDTH - 1);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t state;

    // Only the youngest SYNC_WIDTH-1 bits need storing: together with the
    // incoming bit they form the full candidate window, the oldest bit would
    // be shifted out on the very edge it is compared.
    logic [SYNC_WIDTH-2:0] sync_hist;
    logic [CNT_W-1:0]      fill_cnt;

    // Likewise the byte shifter keeps the 7 bits already received; the 8th
    // arrives on the edge that writes the byte out.
    logic [6:0]            byte_sr;
    logic [2:0]            bit_cnt;
    logic [IDX_W-1:0]      byte_idx;

    logic [SYNC_WIDTH-1:0] next_sync;
    logic [SYNC_WIDTH-1:0] sync_diff;
    logic [CNT_W-1:0]      sync_dist;
    logic [CNT_W-1:0]      fill_next;
    logic                  sync_hit;
    logic [7:0]            byte_next;

    assign next_sync = {sync_hist, bit_in};
    assign sync_diff = next_sync ^ SYNC_WORD;
    assign fill_next = (fill_cnt == FILL_FULL) ? fill_cnt : fill_cnt + CNT_W'(1);
    assign byte_next = {bit_in, byte_sr};

    // Hamming distance between the candidate window and the sync word.
    always_comb begin
        sync_dist = '0;
        for (int i = 0; i < SYNC_WIDTH; i++) begin
            sync_dist = sync_dist + CNT_W'(sync_diff[i]);
        end
    end

    // The fill guard stops the zeroed history from contributing to a match:
    // a full SYNC_WIDTH genuine bits must have been seen since entering hunt.
    assign sync_hit = (sync_dist <= TOL_CNT) && (fill_next == FILL_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_HUNT;
            sync_hist  <= '0;
            fill_cnt   <= '0;
            byte_sr    <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            sys_packet <= '0;
            ready      <= 1'b0;
            sync_lock  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                S_HUNT: begin
                    if (bit_valid) begin
                        sync_hist <= next_sync[SYNC_WIDTH-2:0];
                        fill_cnt  <= fill_next;
                        if (sync_hit) begin
                            state     <= S_COLLECT;
                            sync_lock <= 1'b1;
                            bit_cnt   <= '0;
                            byte_idx  <= '0;
                        end
                    end
                end

                S_COLLECT: begin
                    if (bit_valid) begin
                        byte_sr <= byte_next[7:1];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            sys_packet[byte_idx] <= byte_next;
                            if (byte_idx == LAST_IDX) begin
                                state <= S_HOLD;
                                ready <= 1'b1;
                            end else begin
                                byte_idx <= byte_idx + IDX_W'(1);
                            end
                        end
                    end
                end

                S_HOLD: begin
                    // A bit arriving here is lost even on the done cycle, so
                    // the next hunt starts from an empty history.
                    if (bit_valid) begin
                        overrun <= 1'b1;
                    end
                    if (done) begin
                        state     <= S_HUNT;
                        ready     <= 1'b0;
                        sync_lock <= 1'b0;
                        sync_hist <= '0;
                        fill_cnt  <= '0;
                    end
                end

                default: begin
                    state <= S_HUNT;
                end
            endcase
        end
    end

endmodule

// File: doc/bpsk_packet_assemble.md
# bpsk_packet_assemble

Recovers framed packets from the demodulated BPSK bit stream and presents them to the UART encoder as a parallel byte array. It hunts for a programmable sync word, tolerating a configurable number of bit errors. After lock it collects `PACKET_WIDTH` bytes LSB-first, then holds the packet with `ready` high until downstream signals `done`. It sits between the bit-slicer/demodulator and `uart_encode`.

## Interface
- `PACKET_WIDTH`, default 4: payload bytes per packet (≥1).
- `SYNC_WIDTH`, default 16: sync word length in bits (2..32).
- `SYNC_WORD`, default 16'h2DD4: sync pattern; first bit on air is the MSB.
- `SYNC_TOL`, default 1: maximum Hamming distance accepted as a match.
- `clk` input 1: single system clock; all logic on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `bit_in` input 1: demodulated bit; valid only when `bit_valid`=1.
- `bit_valid` input 1: one-cycle strobe per recovered bit.
- `done` input 1: downstream finished with the held packet; sampled only in HOLD.
- `sys_packet` output `[PACKET_WIDTH-1:0][7:0]`: assembled packet; byte 0 is the first received.
- `ready` output 1: packet complete and stable.
- `sync_lock` output 1: high in COLLECT and HOLD.
- `overrun` output 1: one-cycle pulse per `bit_valid` dropped in HOLD.

## Operation
- Reset values: state=HUNT, `sys_packet`=0, `ready`=0, `sync_lock`=0, `overrun`=0, sync shift register=0, fill counter=0, bit/byte counters=0.
- HUNT:
  - On `bit_valid`: `sync_sr <= {sync_sr[SYNC_WIDTH-2:0], bit_in}`, and the fill counter increments, saturating at `SYNC_WIDTH`.
  - A match is `popcount(next_sync_sr ^ SYNC_WORD) <= SYNC_TOL` AND the fill count including this bit is ≥ `SYNC_WIDTH`.
  - On a match: go to COLLECT with bit_cnt=0, byte_idx=0.
  - The popcount is combinational over `SYNC_WIDTH` bits; widths follow `$clog2(SYNC_WIDTH+1)`.
- COLLECT:
  - On `bit_valid`: `byte_sr <= {bit_in, byte_sr[7:1]}` (LSB-first), and bit_cnt increments (3 bits).
  - When bit_cnt==7: `sys_packet[byte_idx] <= {bit_in, byte_sr[7:1]}` and bit_cnt wraps to 0.
    - If byte_idx==PACKET_WIDTH-1: go to HOLD and set `ready`<=1.
    - Otherwise byte_idx increments.
  - `sys_packet` bytes may change during COLLECT; consumers use it only while `ready`=1.
- HOLD:
  - `sys_packet` is frozen.
  - On `done`=1: `ready`<=0, go to HUNT, and clear the sync shift register and fill counter so a new full sync word is required.
  - Any `bit_valid` in HOLD is discarded and `overrun`<=1 for one cycle. This includes the cycle in which `done` is accepted; that bit does not enter the sync shift register.
- `done` in HUNT/COLLECT: ignored.
- There is no timeout or abort; a lost carrier leaves the block in COLLECT until more bits arrive or reset.
- `rst_n` low at any time, including mid-COLLECT or in HOLD, returns all state to reset values immediately. A partial packet is discarded.

## Timing
- All outputs are registered.
- `sync_lock` rises on the edge sampling the final sync bit.
- `ready` rises on the edge sampling the 8·`PACKET_WIDTH`-th payload bit, i.e. one cycle after that `bit_valid`.
- `ready` falls on the edge sampling `done`=1; the earliest new lock is after `SYNC_WIDTH` further bits.
- `bit_valid` may be asserted on consecutive cycles; the block accepts one bit per cycle with no stall.
- `overrun` is high exactly in the cycle after each dropped `bit_valid`.

## Test plan
- **Clean packet:**
  - Stimulus: defaults, 8 idle zero bits, then 16'h2DD4 MSB-first, then bytes A5,3C,01,FF LSB-first, one bit every 4 cycles.
  - Response: `sync_lock` high after the 24th bit; `ready`=1 one cycle after the 56th bit; `sys_packet`={FF,01,3C,A5} (byte 3 to byte 0); `overrun` never asserted.
- **Sync tolerance:**
  - Stimulus: sync word 16'h2DC4 (1 bit error).
  - Response: locks, and the payload is captured correctly.
  - Stimulus: 16'h2CC4 (2 bit errors).
  - Response: no lock; `ready` stays 0 through 64 following random-free zero bits.
- **Hold/overrun:**
  - Stimulus: after `ready`, 3 `bit_valid` with `done`=0, then `done` coincident with a 4th `bit_valid`.
  - Response: `overrun` pulses 4 times; `sys_packet` unchanged; `ready`=0 and `sync_lock`=0 one cycle after `done`.
- **Back-to-back:**
  - Stimulus: second frame (sync + 11,22,33,44) starting the cycle after `done`, with continuous `bit_valid`.
  - Response: second `ready` after 48 more bits; `sys_packet`={44,33,22,11}.
- **Reset mid-operation:**
  - Stimulus: `rst_n` low for 1 cycle after 13 payload bits.
  - Response: all outputs 0 immediately. A following full frame with bytes 0F,F0,AA,55 yields `sys_packet`={55,AA,F0,0F}.
- **Fill guard:**
  - Stimulus: `SYNC_WORD`=16'h0001, `SYNC_TOL`=0, a single `bit_in`=1 right after reset.
  - Response: no lock. Lock occurs only after 15 zeros then a 1 have been shifted.
